// File: rtl/hd44780_write_engine_if.sv
// Write handshake between content logic and the HD44780 write engine.
// The master presents {rs, data} with valid; the engine (slave) answers with ready.
`timescale 1ns/1ps
interface hd44780_write_engine_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/hd44780_write_engine.sv
// HD44780 bus master: power-on init, then one {RS, byte} write per handshake with
// setup / E-pulse / execution delays. Define LCD_4BIT_EN for a 4-bit data bus.
`timescale 1ns/1ps
module hd44780_write_engine #(
  parameter int         T_POWERUP_CYC = 2000000,
  parameter int         T_SETUP_CYC   = 4,
  parameter int         T_E_HIGH_CYC  = 25,
  parameter int         T_EXEC_CYC    = 2500,
  parameter int         T_CLEAR_CYC   = 82000,
  parameter logic [7:0] INIT_DISPCTL  = 8'h0F
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  hd44780_write_engine_if.slave       wr,
  output logic                        init_done,
  output logic                        busy,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic                        lcd_e,
  output logic [7:0]                  lcd_db
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(imax(T_POWERUP_CYC, T_SETUP_CYC), imax(T_E_HIGH_CYC, T_EXEC_CYC)),
                              T_CLEAR_CYC);
  localparam int CNT_W = $clog2(T_MAX) + 1;

`ifdef LCD_4BIT_EN
  localparam int INIT_LEN = 8;
`else
  localparam int INIT_LEN = 5;
`endif

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    EHIGH,
`ifdef LCD_4BIT_EN
    GAP,
`endif
    EXEC
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               init_done_q, init_done_d;
`ifdef LCD_4BIT_EN
  logic               nib_lo_q, nib_lo_d;
  logic               single_q, single_d;
`endif

`ifdef LCD_4BIT_EN
  // First four entries are lone high nibbles that switch the controller to 4-bit mode.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return 8'h30;
      4'd3:             return 8'h20;
      4'd4:             return 8'h28;
      4'd5:             return INIT_DISPCTL;
      4'd6:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  function automatic logic init_single(input logic [3:0] idx);
    return idx < 4'd4;
  endfunction
`else
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: return 8'h38;
      4'd2:       return INIT_DISPCTL;
      4'd3:       return 8'h01;
      default:    return 8'h06;
    endcase
  endfunction
`endif

  // Clear (0x01) and return-home (0x02/0x03) instructions need the long wait.
  function automatic logic is_long_wait(input logic rs, input logic [7:0] d);
    return !rs && ((d == 8'h01) || (d[7:1] == 7'b0000001));
  endfunction

  function automatic logic tick(input logic [CNT_W-1:0] c, input int len);
    return c == CNT_W'(len - 1);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
`ifdef LCD_4BIT_EN
    nib_lo_d    = nib_lo_q;
    single_d    = single_q;
`endif
    case (state_q)
      PWRUP: if (tick(cnt_q, T_POWERUP_CYC)) state_d = INIT;
      INIT: begin
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q);
        idx_d   = idx_q + 4'd1;
`ifdef LCD_4BIT_EN
        nib_lo_d = 1'b0;
        single_d = init_single(idx_q);
`endif
        state_d = SETUP;
      end
      IDLE: if (wr.wr_valid) begin
        rs_d    = wr.wr_rs;
        data_d  = wr.wr_data;
`ifdef LCD_4BIT_EN
        nib_lo_d = 1'b0;
        single_d = 1'b0;
`endif
        state_d = SETUP;
      end
      SETUP: if (tick(cnt_q, T_SETUP_CYC)) state_d = EHIGH;
      EHIGH: if (tick(cnt_q, T_E_HIGH_CYC)) begin
`ifdef LCD_4BIT_EN
        state_d = (!nib_lo_q && !single_q) ? GAP : EXEC;
`else
        state_d = EXEC;
`endif
      end
`ifdef LCD_4BIT_EN
      // Hold the high nibble after E falls before presenting the low nibble.
      GAP: if (tick(cnt_q, T_SETUP_CYC)) begin
        nib_lo_d = 1'b1;
        state_d  = SETUP;
      end
`endif
      EXEC: if (tick(cnt_q, is_long_wait(rs_q, data_q) ? T_CLEAR_CYC : T_EXEC_CYC)) begin
        if (init_done_q) begin
          state_d = IDLE;
        end else if (idx_q == 4'(INIT_LEN)) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = INIT;
        end
      end
      default: state_d = PWRUP;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);
    else                      cnt_d = cnt_q;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
`ifdef LCD_4BIT_EN
      nib_lo_q    <= 1'b0;
      single_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
`ifdef LCD_4BIT_EN
      nib_lo_q    <= nib_lo_d;
      single_q    <= single_d;
`endif
    end
  end

  // E decodes straight from the state so an asynchronous reset drops it at once.
  assign lcd_e       = (state_q == EHIGH);
  assign wr.wr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign init_done   = init_done_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
`ifdef LCD_4BIT_EN
  assign lcd_db      = {nib_lo_q ? data_q[3:0] : data_q[7:4], 4'h0};
`else
  assign lcd_db      = data_q;
`endif

endmodule

// File: tb/tb_hd44780_write_engine.sv
// Directed, table-driven bench for hd44780_write_engine with shortened timing parameters.
`timescale 1ns/1ps
module tb_hd44780_write_engine;
  localparam int P_PWR = 100;
  localparam int P_SET = 2;
  localparam int P_EH  = 3;
  localparam int P_EX  = 10;
  localparam int P_CLR = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;
  int         cyc = 0;
  int         rel_cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;

  hd44780_write_engine_if wr_if ();

  hd44780_write_engine #(
    .T_POWERUP_CYC(P_PWR), .T_SETUP_CYC(P_SET), .T_E_HIGH_CYC(P_EH),
    .T_EXEC_CYC(P_EX), .T_CLEAR_CYC(P_CLR), .INIT_DISPCTL(8'h0F)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .wr(wr_if),
    .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
    $fatal(1);
  end

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         min_pre;
    int         max_pre;
  } ivec_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         wt;
  } wvec_t;

  ivec_t iexp[$];
  wvec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  // Called at a negedge with E low; returns at the first negedge after E falls.
  task automatic capture_pulse(input int budget, output bit ok, output int pre, output bit prs,
                               output logic [7:0] pdb, output int width, output bit stable);
    pre = 0; width = 0; stable = 1'b1; prs = 1'b0; pdb = '0;
    while (!lcd_e && pre < budget) begin @(negedge clk); pre++; end
    ok = lcd_e;
    if (!ok) return;
    prs = lcd_rs; pdb = lcd_db;
    while (lcd_e && width < budget) begin
      if (lcd_rs !== prs || lcd_db !== pdb) stable = 1'b0;
      width++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!wr_if.wr_ready && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic run_init_check(input string tag);
    bit ok, prs, st; int pre, w, n; logic [7:0] pdb;
    for (int i = 0; i < iexp.size(); i++) begin
      capture_pulse(400, ok, pre, prs, pdb, w, st);
      check($sformatf("%s_pulse%0d_seen", tag, i), 32'(ok), 32'd1);
      if (!ok) return;
      if (i == 0) check_range($sformatf("%s_first_rise", tag), cyc - rel_cyc, P_PWR, P_PWR + 20);
      else        check_range($sformatf("%s_pre%0d", tag, i), pre, iexp[i].min_pre, iexp[i].max_pre);
      check($sformatf("%s_rs%0d", tag, i), 32'(prs), 32'(iexp[i].rs));
      check($sformatf("%s_db%0d", tag, i), 32'(pdb), 32'(iexp[i].db));
      check($sformatf("%s_width%0d", tag, i), 32'(w), 32'(P_EH));
      check($sformatf("%s_stable%0d", tag, i), 32'(st), 32'd1);
    end
    wait_ready(100, n);
    check_range($sformatf("%s_last_exec", tag), n, P_EX, P_EX + 1);
    check($sformatf("%s_ready", tag), 32'(wr_if.wr_ready), 32'd1);
    check($sformatf("%s_init_done", tag), 32'(init_done), 32'd1);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
  endtask

  task automatic start_write(input logic rs, input logic [7:0] d);
    wr_if.wr_valid = 1'b1; wr_if.wr_rs = rs; wr_if.wr_data = d;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

`ifndef LCD_4BIT_EN
  task automatic do_write(input int k, input logic rs, input logic [7:0] d, input int exp_wt);
    bit ok, prs, st; int pre, w, n; logic [7:0] pdb;
    start_write(rs, d);
    check($sformatf("w%0d_ready_drop", k), 32'(wr_if.wr_ready), 32'd0);
    check($sformatf("w%0d_early_rs_db", k), {23'd0, lcd_rs, lcd_db}, {23'd0, rs, d});
    check($sformatf("w%0d_busy", k), 32'(busy), 32'd1);
    capture_pulse(100, ok, pre, prs, pdb, w, st);
    check($sformatf("w%0d_rise_lat", k), 32'(pre + 1), 32'(1 + P_SET));
    check($sformatf("w%0d_width", k), 32'(w), 32'(P_EH));
    check($sformatf("w%0d_pulse_rs_db", k), {23'd0, prs, pdb}, {23'd0, rs, d});
    check($sformatf("w%0d_stable", k), 32'(st), 32'd1);
    wait_ready(200, n);
    check($sformatf("w%0d_exec_wait", k), 32'(n), 32'(exp_wt));
  endtask
`endif

  initial begin
    bit ok, prs, st; int pre, w, n; logic [7:0] pdb;
    logic [7:0] seq [3];
`ifdef LCD_4BIT_EN
    iexp.push_back('{1'b0, 8'h30, 0, 0});
    iexp.push_back('{1'b0, 8'h30, 2, 20});
    iexp.push_back('{1'b0, 8'h30, 2, 20});
    iexp.push_back('{1'b0, 8'h20, 2, 20});
    iexp.push_back('{1'b0, 8'h20, 2, 20});
    iexp.push_back('{1'b0, 8'h80, 2*P_SET, 2*P_SET});
    iexp.push_back('{1'b0, 8'h00, 2, 20});
    iexp.push_back('{1'b0, 8'hF0, 2*P_SET, 2*P_SET});
    iexp.push_back('{1'b0, 8'h00, 2, 20});
    iexp.push_back('{1'b0, 8'h10, 2*P_SET, 2*P_SET});
    iexp.push_back('{1'b0, 8'h00, P_CLR + P_SET, P_CLR + 20});
    iexp.push_back('{1'b0, 8'h60, 2*P_SET, 2*P_SET});
`else
    iexp.push_back('{1'b0, 8'h38, 0, 0});
    iexp.push_back('{1'b0, 8'h38, 2, 20});
    iexp.push_back('{1'b0, 8'h0F, 2, 20});
    iexp.push_back('{1'b0, 8'h01, 2, 20});
    iexp.push_back('{1'b0, 8'h06, P_CLR + P_SET, P_CLR + 20});
`endif
    tbl.push_back('{1'b1, 8'h41, P_EX});
    tbl.push_back('{1'b0, 8'h01, P_CLR});
    tbl.push_back('{1'b0, 8'hC0, P_EX});
    tbl.push_back('{1'b1, 8'h01, P_EX});
    tbl.push_back('{1'b0, 8'h02, P_CLR});
    tbl.push_back('{1'b0, 8'h03, P_CLR});
    tbl.push_back('{1'b0, 8'h04, P_EX});

    rst = 1'b1;
    wr_if.wr_valid = 1'b0; wr_if.wr_rs = 1'b0; wr_if.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", 32'(lcd_e), 32'd0);
    check("rst_lcd_rs_rw", {30'd0, lcd_rs, lcd_rw}, 32'd0);
    check("rst_lcd_db", 32'(lcd_db), 32'd0);
    check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // A write held during power-up must be ignored.
    rst = 1'b0; rel_cyc = cyc;
    wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h55;
    repeat (50) @(negedge clk);
    check("pwrup_ready_low", 32'(wr_if.wr_ready), 32'd0);
    check("pwrup_no_e", 32'(lcd_e), 32'd0);
    wr_if.wr_valid = 1'b0;
    run_init_check("init");

`ifndef LCD_4BIT_EN
    foreach (tbl[k]) do_write(k, tbl[k].rs, tbl[k].d, tbl[k].wt);

    // Back-to-back writes with valid held high throughout.
    seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h33;
    fork
      begin
        int m;
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
          wr_if.wr_data = seq[i];
          wait_ready(200, m);
          @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
      end
      begin
        bit ok2, prs2, st2; int pre2, w2; logic [7:0] pdb2;
        for (int i = 0; i < 3; i++) begin
          capture_pulse(100, ok2, pre2, prs2, pdb2, w2, st2);
          check($sformatf("b2b_pulse%0d", i), {22'd0, ok2, prs2, pdb2}, {22'd0, 1'b1, 1'b1, seq[i]});
          check($sformatf("b2b_stable%0d", i), {31'd0, st2}, 32'd1);
        end
      end
    join
    capture_pulse(40, ok, pre, prs, pdb, w, st);
    check("b2b_no_extra_pulse", 32'(ok), 32'd0);
`else
    start_write(1'b1, 8'h5A);
    check("nib_ready_drop", 32'(wr_if.wr_ready), 32'd0);
    capture_pulse(100, ok, pre, prs, pdb, w, st);
    check("nib_hi_lat", 32'(pre + 1), 32'(1 + P_SET));
    check("nib_hi_pulse", {22'd0, ok, prs, pdb}, {22'd0, 1'b1, 1'b1, 8'h50});
    check("nib_hi_width_stable", {w[15:0], 15'd0, st}, {16'(P_EH), 16'd1});
    capture_pulse(100, ok, pre, prs, pdb, w, st);
    check("nib_lo_gap", 32'(pre), 32'(2 * P_SET));
    check("nib_lo_pulse", {22'd0, ok, prs, pdb}, {22'd0, 1'b1, 1'b1, 8'hA0});
    check("nib_lo_width_stable", {w[15:0], 15'd0, st}, {16'(P_EH), 16'd1});
    wait_ready(200, n);
    check("nib_exec_wait", 32'(n), 32'(P_EX));
`endif

    // Reset while E is high.
    wait_ready(200, n);
    start_write(1'b1, 8'h42);
    n = 0;
    while (!lcd_e && n < 50) begin @(negedge clk); n++; end
    check("midrst_e_was_high", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_e_drop", 32'(lcd_e), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_ready_busy", {30'd0, wr_if.wr_ready, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0; rel_cyc = cyc;
    run_init_check("reinit");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hd44780_write_engine.md
Name: hd44780_write_engine

Overview:
- Timing-correct HD44780 bus master between content logic (text/number formatters, the BCD digit path) and the character-LCD pins.
- Runs the power-on init sequence autonomously.
- Then accepts one {RS, byte} write per valid/ready handshake and drives RS/RW/E/DB with setup, E-pulse and execution delays counted in CLOCK_50 cycles.
- Replaces hand-sequenced per-character E toggling in display logic.

Parameters:
- T_POWERUP_CYC, 2000000, wait after reset before first init write (40 ms at 50 MHz)
- T_SETUP_CYC, 4, cycles RS/DB are stable before E rises (min 1)
- T_E_HIGH_CYC, 25, E high width in cycles (min 1)
- T_EXEC_CYC, 2500, wait after E falls for normal instructions/data
- T_CLEAR_CYC, 82000, wait after E falls for clear (0x01) / home (0x02, 0x03)
- INIT_DISPCTL, 8'h0F, display-control byte sent during init (display, cursor, blink on)

Ports:
- CLOCK_50  in   1  system clock
- RESET     in   1  asynchronous, active-high reset
- wr_valid  in   1  write request
- wr_ready  out  1  engine can accept a write this cycle
- wr_rs     in   1  0 = instruction, 1 = data
- wr_data   in   8  byte to write
- init_done out  1  init sequence finished; stays high until RESET
- busy      out  1  high whenever not in IDLE
- lcd_rs    out  1  LCD RS
- lcd_rw    out  1  LCD R/W, constant 0
- lcd_e     out  1  LCD enable
- lcd_db    out  8  LCD data bus

Behaviour:
- Reset values (asynchronous): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, wr_ready=0, init_done=0, busy=1, state=PWRUP, delay counter=0, init index=0.
- PWRUP: count T_POWERUP_CYC cycles, then go to INIT.
- INIT: issue the init list in order, each via the SETUP/EHIGH/EXEC path:
  - 8-bit list: 0x38, 0x38, INIT_DISPCTL, 0x01, 0x06, all with RS=0.
  - After the last EXEC: init_done=1, go to IDLE.
- IDLE: wr_ready=1 and busy=0.
  - Accept when wr_valid & wr_ready; latch wr_rs/wr_data; go to SETUP.
  - wr_ready drops in the cycle after accept. wr_valid while not ready is ignored, not queued.
- SETUP: lcd_rs/lcd_db drive the latched values from the first SETUP cycle; lcd_e=0 for T_SETUP_CYC cycles, then EHIGH.
- EHIGH: lcd_e=1 for exactly T_E_HIGH_CYC cycles; RS/DB held stable.
- EXEC: lcd_e=0; RS/DB held. Wait T_CLEAR_CYC if RS=0 and data[7:1]==7'b0000001 or data==8'h01, else T_EXEC_CYC. Then IDLE (or the next INIT entry).
- lcd_e rises no earlier than T_SETUP_CYC cycles after a DB change. DB never changes while lcd_e=1.
- Delay counter width: $clog2 of the largest timing parameter + 1. It reloads to 0 on every state change; no wrap within a phase.
- Writes presented during PWRUP/INIT are not accepted (wr_ready=0).
- RESET asserted mid-transfer, including with E high: E drops immediately, PWRUP restarts, init_done clears.
- Accept-to-E-rise latency: 1 + T_SETUP_CYC cycles. Accept-to-next-ready: 1 + T_SETUP_CYC + T_E_HIGH_CYC + exec wait.

Optional Feature:
- Macro: LCD_4BIT_EN.
- Defined (4-bit bus):
  - Only lcd_db[7:4] carry data; lcd_db[3:0] driven 0.
  - Init list: single nibbles 0x3, 0x3, 0x3, 0x2 (each one E pulse + T_EXEC_CYC); then bytes 0x28, INIT_DISPCTL, 0x01, 0x06.
  - Every byte is high nibble: SETUP, EHIGH, then T_SETUP_CYC gap; then low nibble: SETUP, EHIGH, then EXEC.
- Undefined: full 8-bit behaviour above; no nibble logic synthesized.

Test Plan:
- Small params (POWERUP=100, SETUP=2, EHIGH=3, EXEC=10, CLEAR=40), RESET pulse → wr_ready=0 for 100 cycles; five E pulses with DB=0x38,0x38,0x0F,0x01,0x06 and RS=0; gap after 0x01 ≥ 40 cycles; then init_done=1, wr_ready=1.
- After init, write rs=1 data=0x41 → lcd_rs=1, DB=0x41 from the next cycle; E rises 3 cycles after accept, high 3 cycles; wr_ready returns 1+2+3+10=16 cycles after accept.
- Back-to-back writes rs=1 0x31,0x32,0x33 with wr_valid held high → exactly three E pulses in order; DB stable throughout each E-high window.
- Write rs=0 0x01, then rs=0 0xC0 → CLEAR wait (40) after the first, EXEC wait (10) after the second; rs=1 0x01 uses EXEC wait.
- Assert RESET during EHIGH of a write → lcd_e=0 the same cycle, init_done=0, full init sequence replays.
- With LCD_4BIT_EN, write rs=1 0x5A → two E pulses with lcd_db[7:4]=0x5 then 0xA, lcd_db[3:0]=0 throughout.
